lcd_bus_driver: RTL and testbench

//  Physical-layer stage downstream of the LCD display controller. Takes one

---
 rtl/lcd_bus_driver.sv | 140 ++++++++++++++
 tb/tb_lcd_bus_driver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write-only bus driver: runs power-up wait and init ROM, then
// writes one byte per valid/ready handshake with setup/pulse/hold/exec timing.
module lcd_bus_driver #(
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 6,
  parameter int T_HOLD    = 2,
  parameter int T_EXEC    = 600,
  parameter int T_CLEAR   = 24000,
  parameter int T_POWERUP = 240000
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       busy,
  output logic       E,
  output logic       RS,
  output logic       RW,
  output logic [7:0] DB
);

  localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
  localparam int MAX_C = (T_CLEAR > T_POWERUP) ? T_CLEAR : T_POWERUP;
  localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CW = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    SETUP,
    PULSE,
    HOLD,
    EXEC,
    IDLE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   curLen;
  logic [2:0]      romIdx_q;
  logic            e_q;
  logic            rs_q;
  logic [7:0]      db_q;
  logic            ready_q;
  logic            done_q;
  logic            busy_q;
  logic            lastCycle;
  logic            longWait;

  function automatic logic [7:0] romByte(input logic [2:0] idx);
    case (idx)
      3'd0:    romByte = 8'h38;
      3'd1:    romByte = 8'h0C;
      3'd2:    romByte = 8'h06;
      default: romByte = 8'h01;
    endcase
  endfunction

  // Clear and home need the long execution wait; every other byte uses the short one.
  always_comb begin
    longWait = !rs_q && (db_q[7:2] == 6'd0) && (db_q != 8'd0);
    curLen   = CW'(1);
    case (state_q)
      PWRUP:   curLen = CW'(T_POWERUP);
      SETUP:   curLen = CW'(T_SETUP);
      PULSE:   curLen = CW'(T_PULSE);
      HOLD:    curLen = CW'(T_HOLD);
      EXEC:    curLen = longWait ? CW'(T_CLEAR) : CW'(T_EXEC);
      default: curLen = CW'(1);
    endcase
    lastCycle = (count_q == curLen - CW'(1));
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q  <= PWRUP;
      count_q  <= '0;
      romIdx_q <= 3'd0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= 8'h00;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      // INIT and IDLE have length 1, so the counter sits at 0 there and every state is entered at 0.
      count_q <= lastCycle ? '0 : count_q + CW'(1);
      case (state_q)
        PWRUP: if (lastCycle) state_q <= INIT;
        INIT: begin
          state_q  <= SETUP;
          rs_q     <= 1'b0;
          db_q     <= romByte(romIdx_q);
          romIdx_q <= romIdx_q + 3'd1;
        end
        SETUP: if (lastCycle) begin
          state_q <= PULSE;
          e_q     <= 1'b1;
        end
        PULSE: if (lastCycle) begin
          state_q <= HOLD;
          e_q     <= 1'b0;
        end
        HOLD: if (lastCycle) state_q <= EXEC;
        EXEC: if (lastCycle) begin
          if (romIdx_q == 3'd4) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= INIT;
          end
        end
        IDLE: if (in_valid) begin
          state_q <= SETUP;
          rs_q    <= in_rs;
          db_q    <= in_data;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        default: state_q <= PWRUP;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign init_done = done_q;
  assign busy      = busy_q;
  assign E         = e_q;
  assign RS        = rs_q;
  assign RW        = 1'b0;
  assign DB        = db_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver: event-timeline reference model checked every cycle,
// plus a table of directed writes and hand sequences for init and mid-pulse reset.
module tb_lcd_bus_driver;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int TE = 4;
  localparam int TC = 8;
  localparam int PU = 5;

  logic       mclk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       init_done;
  logic       busy;
  logic       E;
  logic       RS;
  logic       RW;
  logic [7:0] DB;

  always #5 mclk = ~mclk;

  lcd_bus_driver #(
    .T_SETUP(S), .T_PULSE(P), .T_HOLD(H),
    .T_EXEC(TE), .T_CLEAR(TC), .T_POWERUP(PU)
  ) dut (
    .mclk(mclk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
    .in_ready(in_ready), .init_done(init_done), .busy(busy),
    .E(E), .RS(RS), .RW(RW), .DB(DB)
  );

  // A write is an event record: edge it was latched on, E rise/fall edges, and its byte.
  typedef struct {
    int       latch;
    int       rise;
    int       fall;
    bit       rs;
    bit [7:0] db;
  } write_t;

  typedef struct {
    bit       rs;
    bit [7:0] data;
    int       expWait;
    int       expHigh;
  } vec_t;

  write_t   writes[$];
  bit [7:0] initRom[4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  int       cyc = 0;
  int       readyAt = 0;
  int       initDoneAt = 0;
  bit       modelValid = 1'b0;
  bit       modelReady = 1'b0;
  int       nVec = 0;
  int       nMis = 0;

  function automatic int waitFor(bit rs, bit [7:0] db);
    return (!rs && db[7:2] == 6'd0 && db != 8'd0) ? TC : TE;
  endfunction

  function automatic int schedule(int k, bit rs, bit [7:0] db);
    write_t w;
    w.latch = k;
    w.rise  = k + S;
    w.fall  = k + S + P;
    w.rs    = rs;
    w.db    = db;
    writes.push_back(w);
    return k + S + P + H + waitFor(rs, db);
  endfunction

  function automatic void modelReset(int r);
    int k;
    int done;
    writes.delete();
    k = r + PU + 1;
    done = 0;
    for (int i = 0; i < 4; i++) begin
      done = schedule(k, 1'b0, initRom[i]);
      k = done + 1;
    end
    readyAt    = done;
    initDoneAt = done;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit       expE;
    bit       expRs;
    bit [7:0] expDb;
    bit       expReady;
    expE = 1'b0;
    expRs = 1'b0;
    expDb = 8'h00;
    foreach (writes[i]) begin
      if (writes[i].rise <= cyc && cyc < writes[i].fall) expE = 1'b1;
      if (writes[i].latch <= cyc) begin
        expRs = writes[i].rs;
        expDb = writes[i].db;
      end
    end
    expReady = (cyc >= readyAt);
    check("E", 32'(E), 32'(expE));
    check("RS", 32'(RS), 32'(expRs));
    check("DB", 32'(DB), 32'(expDb));
    check("RW", 32'(RW), 32'd0);
    check("in_ready", 32'(in_ready), 32'(expReady));
    check("busy", 32'(busy), 32'(!expReady));
    check("init_done", 32'(init_done), 32'(cyc >= initDoneAt));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit rs, input bit [7:0] d);
    @(negedge mclk);
    rst      = r;
    in_valid = v;
    in_rs    = rs;
    in_data  = d;
    @(posedge mclk);
    cyc++;
    if (r) begin
      modelReset(cyc);
      modelValid = 1'b1;
    end else if (v && modelReady) begin
      readyAt = schedule(cyc, rs, d);
    end
    modelReady = modelValid && (cyc >= readyAt);
    #1;
    if (modelValid) checkOutput();
  endtask

  task automatic waitReady(input int limit);
    int n;
    n = 0;
    while (!in_ready && n < limit) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    check("readyWait", 32'(in_ready), 32'd1);
  endtask

  // Runs from just after a reset edge to init completion with noisy in_valid.
  task automatic initSequence(input string tag);
    int  rises;
    bit  prevE;
    int  n;
    rises = 0;
    prevE = E;
    n = 0;
    while (!in_ready && n < 200) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      if (E && !prevE) rises++;
      prevE = E;
      n++;
    end
    check({tag, "_pulses"}, 32'(rises), 32'd4);
    check({tag, "_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   d;
    int   high;
    int   n;

    vecs[0] = '{rs: 1'b1, data: 8'h41, expWait: 8,  expHigh: 2};
    vecs[1] = '{rs: 1'b0, data: 8'h01, expWait: 12, expHigh: 2};
    vecs[2] = '{rs: 1'b0, data: 8'h80, expWait: 8,  expHigh: 2};
    vecs[3] = '{rs: 1'b0, data: 8'h02, expWait: 12, expHigh: 2};
    vecs[4] = '{rs: 1'b0, data: 8'h03, expWait: 12, expHigh: 2};
    vecs[5] = '{rs: 1'b0, data: 8'h00, expWait: 8,  expHigh: 2};
    vecs[6] = '{rs: 1'b0, data: 8'h04, expWait: 8,  expHigh: 2};
    vecs[7] = '{rs: 1'b1, data: 8'h01, expWait: 8,  expHigh: 2};

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    initSequence("init1");

    for (int i = 0; i < 8; i++) begin
      waitReady(100);
      applyStimulus(1'b0, 1'b1, vecs[i].rs, vecs[i].data);
      check("latchRS", 32'(RS), 32'(vecs[i].rs));
      check("latchDB", 32'(DB), 32'(vecs[i].data));
      d = 0;
      high = 0;
      while (!in_ready && d < 100) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        d++;
        if (E) high++;
      end
      check("readyDelay", 32'(d), 32'(vecs[i].expWait));
      check("eHigh", 32'(high), 32'(vecs[i].expHigh));
    end

    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'(i) ^ 8'hA5);
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
    end

    waitReady(100);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
    n = 0;
    while (!E && n < 10) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    check("pulseSeen", 32'(E), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    check("abortE", 32'(E), 32'd0);
    check("abortDone", 32'(init_done), 32'd0);
    check("abortReady", 32'(in_ready), 32'd0);
    initSequence("init2");

    waitReady(100);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h7E);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
